// File: rtl/sprite_line_buffer_if.sv
// Sprite line-load handshake: descriptor fields from the sprite engine,
// line_busy back from the line buffer.
interface sprite_line_buffer_if #(
    parameter int XBITS = 10
);
    logic             line_load;
    logic             hFlip;
    logic [1:0]       line_z;
    logic [3:0]       line_palette;
    logic [XBITS-1:0] line_addr;
    logic             tile_table;
    logic [3:0]       tile_x;
    logic [3:0]       tile_y_total;
    logic [2:0]       tile_y_offset;
    logic [2:0]       sizeX;
    logic [2:0]       first;
    logic [2:0]       last;
    logic             line_busy;

    modport master (
        output line_load, hFlip, line_z, line_palette, line_addr, tile_table,
               tile_x, tile_y_total, tile_y_offset, sizeX, first, last,
        input  line_busy
    );

    modport slave (
        input  line_load, hFlip, line_z, line_palette, line_addr, tile_table,
               tile_x, tile_y_total, tile_y_offset, sizeX, first, last,
        output line_busy
    );
endinterface

// File: rtl/sprite_line_buffer.sv
// Double-buffered sprite scanline store: renders one sprite slice per line_load
// with z resolution; display reads clear entries. Optional: SPRITE_COLLISION_EN.
module sprite_line_buffer #(
    parameter int WIDTH        = 640,
    parameter int XBITS        = 10,
    parameter int TILE_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    sprite_line_buffer_if.slave line,
    output logic [11:0]      tile_addr,
    input  logic [31:0]      tile_data,
    input  logic             scanline_start,
    input  logic             pixel_rd,
    input  logic [XBITS-1:0] pixel_x,
    output logic [7:0]       pixel_out
`ifdef SPRITE_COLLISION_EN
    ,
    output logic             collision
`endif
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] READ  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] CLEAR = 3'd5;

    localparam logic [XBITS:0]   WIDTH_L = (XBITS+1)'(WIDTH);
    localparam logic [XBITS-1:0] X_LAST  = XBITS'(WIDTH - 1);
    localparam logic [1:0]       LAT     = 2'(TILE_LATENCY);

    // entry = {z[1:0], palette[3:0], index[3:0]}
    logic [9:0] mem [2][WIDTH];

    logic [2:0]       state;
    logic             busy;
    logic             bank_sel;
    logic [XBITS-1:0] clr_x;
    logic             d_hflip;
    logic [1:0]       d_z;
    logic [3:0]       d_pal;
    logic [XBITS-1:0] d_addr;
    logic             d_table;
    logic [3:0]       d_tx;
    logic [3:0]       d_ty;
    logic [2:0]       d_tyo;
    logic [2:0]       d_sizex;
    logic [2:0]       col;
    logic [2:0]       eff_last;
    logic [2:0]       pix;
    logic [1:0]       lat_cnt;
    logic [31:0]      word;
    logic [1:0]       rd_z;
    logic [3:0]       rd_idx;

    logic [2:0]       eff_in;
    logic [2:0]       cpos;
    logic [2:0]       ppos;
    logic [XBITS-1:0] x_tgt;
    logic             x_ok;
    logic             pix_ok;
    logic [3:0]       new_idx;
    logic [3:0]       tile_col;
    logic             draw_we;
    logic             disp_bank;

    always_comb begin
        eff_in    = (line.last < line.sizeX) ? line.last : line.sizeX;
        cpos      = d_hflip ? (d_sizex - col) : col;
        ppos      = d_hflip ? (3'd7 - pix) : pix;
        x_tgt     = d_addr + XBITS'({cpos, 3'b000}) + XBITS'(ppos);
        x_ok      = {1'b0, x_tgt} < WIDTH_L;
        pix_ok    = {1'b0, pixel_x} < WIDTH_L;
        new_idx   = word[{pix, 2'b00} +: 4];
        tile_col  = d_tx + {1'b0, col};
        tile_addr = {d_table, d_ty, tile_col, d_tyo};
        disp_bank = ~bank_sel;
        draw_we   = (state == WRITE) && (new_idx != 4'd0) && x_ok &&
                    ((rd_idx == 4'd0) || (d_z >= rd_z));
    end

    assign line.line_busy = busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            busy     <= 1'b1;
            bank_sel <= 1'b0;
            clr_x    <= '0;
            d_hflip  <= 1'b0;
            d_z      <= '0;
            d_pal    <= '0;
            d_addr   <= '0;
            d_table  <= 1'b0;
            d_tx     <= '0;
            d_ty     <= '0;
            d_tyo    <= '0;
            d_sizex  <= '0;
            col      <= '0;
            eff_last <= '0;
            pix      <= '0;
            lat_cnt  <= '0;
            word     <= '0;
            rd_z     <= '0;
            rd_idx   <= '0;
        end else begin
            if (scanline_start)
                bank_sel <= ~bank_sel;
            // the post-reset clearing sweep runs to completion even across a bank swap
            if (state == CLEAR) begin
                if (clr_x == X_LAST) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    clr_x <= clr_x + 1'b1;
                end
            end else if (scanline_start) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (line.line_load && !busy) begin
                            d_hflip  <= line.hFlip;
                            d_z      <= line.line_z;
                            d_pal    <= line.line_palette;
                            d_addr   <= line.line_addr;
                            d_table  <= line.tile_table;
                            d_tx     <= line.tile_x;
                            d_ty     <= line.tile_y_total;
                            d_tyo    <= line.tile_y_offset;
                            d_sizex  <= line.sizeX;
                            col      <= line.first;
                            eff_last <= eff_in;
                            lat_cnt  <= '0;
                            busy     <= 1'b1;
                            state    <= (line.first > eff_in) ? DONE : FETCH;
                        end
                    end
                    FETCH: begin
                        if (lat_cnt == LAT) begin
                            word  <= tile_data;
                            pix   <= '0;
                            state <= READ;
                        end else begin
                            lat_cnt <= lat_cnt + 1'b1;
                        end
                    end
                    READ: begin
                        if (x_ok) begin
                            rd_z   <= mem[bank_sel][x_tgt][9:8];
                            rd_idx <= mem[bank_sel][x_tgt][3:0];
                        end else begin
                            rd_z   <= '0;
                            rd_idx <= '0;
                        end
                        state <= WRITE;
                    end
                    WRITE: begin
                        pix <= pix + 1'b1;
                        if (pix == 3'd7) begin
                            if (col == eff_last) begin
                                state <= DONE;
                            end else begin
                                col     <= col + 1'b1;
                                lat_cnt <= '0;
                                state   <= FETCH;
                            end
                        end else begin
                            state <= READ;
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[0][clr_x] <= '0;
            mem[1][clr_x] <= '0;
        end else begin
            if (draw_we)
                mem[bank_sel][x_tgt] <= {d_z, d_pal, new_idx};
            if (pixel_rd && pix_ok)
                mem[disp_bank][pixel_x] <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_out <= '0;
        end else if (pixel_rd) begin
            if ((state == CLEAR) || !pix_ok)
                pixel_out <= '0;
            else
                pixel_out <= mem[disp_bank][pixel_x][7:0];
        end
    end

`ifdef SPRITE_COLLISION_EN
    always_ff @(posedge clk) begin
        if (rst || scanline_start)
            collision <= 1'b0;
        else if ((state == WRITE) && (new_idx != 4'd0) && x_ok && (rd_idx != 4'd0))
            collision <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_sprite_line_buffer.sv
// Directed-vector bench for sprite_line_buffer with a 1-cycle tile VRAM model.
module tb_sprite_line_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] tile_addr;
    logic [31:0] tile_data = '0;
    logic        scanline_start = 1'b0;
    logic        pixel_rd = 1'b0;
    logic [9:0]  pixel_x = '0;
    logic [7:0]  pixel_out;
`ifdef SPRITE_COLLISION_EN
    logic        collision;
`endif

    logic [31:0] tile_rom [16];
    logic [3:0]  col_log [$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    sprite_line_buffer_if #(.XBITS(10)) line_if ();

    sprite_line_buffer #(
        .WIDTH(640),
        .XBITS(10),
        .TILE_LATENCY(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .line(line_if.slave),
        .tile_addr(tile_addr),
        .tile_data(tile_data),
        .scanline_start(scanline_start),
        .pixel_rd(pixel_rd),
        .pixel_x(pixel_x),
        .pixel_out(pixel_out)
`ifdef SPRITE_COLLISION_EN
        ,
        .collision(collision)
`endif
    );

    always @(posedge clk) tile_data <= tile_rom[tile_addr[6:3]];

    // record the sequence of tile column fields fetched while busy
    always @(negedge clk)
        if (line_if.line_busy && (col_log.size() == 0 || col_log[$] != tile_addr[6:3]))
            col_log.push_back(tile_addr[6:3]);

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_desc(input int unsigned addr, input int unsigned z, input int unsigned pal,
                            input int unsigned hf, input int unsigned sz, input int unsigned f,
                            input int unsigned l, input int unsigned tx);
        line_if.line_addr     = 10'(addr);
        line_if.line_z        = 2'(z);
        line_if.line_palette  = 4'(pal);
        line_if.hFlip         = hf[0];
        line_if.sizeX         = 3'(sz);
        line_if.first         = 3'(f);
        line_if.last          = 3'(l);
        line_if.tile_x        = 4'(tx);
        line_if.tile_table    = 1'b0;
        line_if.tile_y_total  = 4'd0;
        line_if.tile_y_offset = 3'd0;
    endtask

    task automatic pulse_load;
        line_if.line_load = 1'b1;
        tick;
        line_if.line_load = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned limit, output int unsigned n);
        n = 0;
        while (line_if.line_busy && n < limit) begin
            n++;
            tick;
        end
    endtask

    task automatic run_load(input int unsigned addr, input int unsigned z, input int unsigned pal,
                            input int unsigned hf, input int unsigned sz, input int unsigned f,
                            input int unsigned l, input int unsigned tx, output int unsigned n);
        set_desc(addr, z, pal, hf, sz, f, l, tx);
        pulse_load;
        wait_idle(400, n);
    endtask

    task automatic swap;
        scanline_start = 1'b1;
        tick;
        scanline_start = 1'b0;
    endtask

    task automatic read_px(input int unsigned x, input int unsigned exp);
        pixel_rd = 1'b1;
        pixel_x  = 10'(x);
        tick;
        pixel_rd = 1'b0;
        check($sformatf("rd_x%0d", x), pixel_out, exp);
    endtask

    initial begin
        int unsigned n;
        foreach (tile_rom[i]) tile_rom[i] = '0;
        line_if.line_load = 1'b0;
        set_desc(0, 0, 0, 0, 0, 0, 0, 0);

        // reset and clearing sweep
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rst_pixel_out", pixel_out, 0);
        check("rst_sweep_busy", line_if.line_busy, 1);
        wait_idle(2000, n);
        check("rst_busy_low", line_if.line_busy, 0);
        read_px(5, 0);
        read_px(639, 0);

        // basic single-tile draw into bank 0
        tile_rom[0] = 32'h8765_4321;
        run_load(100, 1, 3, 0, 0, 0, 0, 0, n);
        check("basic_busy_cycles", n, 19);
        swap;
        read_px(99, 8'h00);
        for (int i = 0; i < 8; i++) read_px(100 + i, 8'h31 + i);
        read_px(108, 8'h00);
        read_px(100, 8'h00);

        // bank 1: handshake, hFlip multi-tile, boundaries
        set_desc(300, 0, 2, 0, 0, 0, 0, 0);
        pulse_load;
        tick;
        tick;
        set_desc(400, 0, 2, 0, 0, 0, 0, 0);
        pulse_load;
        wait_idle(400, n);
        check("ignored_load_busy", n, 16);

        tile_rom[5] = 32'h0000_000A;
        tile_rom[6] = 32'hB000_0000;
        col_log.delete();
        run_load(500, 1, 4, 1, 1, 0, 1, 5, n);
        check("flip_busy_cycles", n, 37);
        check("flip_col_count", col_log.size(), 2);
        if (col_log.size() == 2) begin
            check("flip_col0", col_log[0], 5);
            check("flip_col1", col_log[1], 6);
        end

        run_load(636, 0, 5, 0, 0, 0, 0, 0, n);
        check("edge_busy_cycles", n, 19);
        run_load(50, 0, 5, 0, 3, 3, 1, 0, n);
        check("empty_busy_cycles", n, 1);
        tile_rom[1] = 32'h1111_1111;
        run_load(20, 0, 6, 0, 0, 0, 2, 0, n);
        check("clamp_busy_cycles", n, 19);

        swap;
`ifdef SPRITE_COLLISION_EN
        check("coll_after_swap", collision, 0);
`endif
        read_px(300, 8'h21);
        read_px(307, 8'h28);
        read_px(400, 8'h00);
        read_px(515, 8'h4A);
        read_px(500, 8'h4B);
        read_px(636, 8'h51);
        read_px(639, 8'h54);
        read_px(640, 8'h00);
        read_px(0, 8'h00);
        read_px(74, 8'h00);
        read_px(20, 8'h61);
        read_px(28, 8'h00);

        // bank 0: z priority and transparency at x=200
        tile_rom[0] = 32'h0000_00FF;
        run_load(200, 2, 1, 0, 0, 0, 0, 0, n);
`ifdef SPRITE_COLLISION_EN
        check("coll_no_overlap", collision, 0);
`endif
        tile_rom[0] = 32'h0000_0C0C;
        run_load(200, 1, 7, 0, 0, 0, 0, 0, n);
`ifdef SPRITE_COLLISION_EN
        check("coll_overlap", collision, 1);
`endif
        tile_rom[0] = 32'h0000_0005;
        run_load(200, 2, 9, 0, 0, 0, 0, 0, n);
        swap;
`ifdef SPRITE_COLLISION_EN
        check("coll_cleared", collision, 0);
`endif
        read_px(200, 8'h95);
        read_px(201, 8'h1F);
        read_px(202, 8'h7C);
        read_px(203, 8'h00);

        // abort mid-slice and load coincident with scanline_start
        tile_rom[0] = 32'h8765_4321;
        set_desc(250, 0, 1, 0, 0, 0, 0, 0);
        pulse_load;
        tick;
        tick;
        swap;
        check("abort_busy", line_if.line_busy, 0);
        line_if.line_load = 1'b1;
        scanline_start    = 1'b1;
        tick;
        line_if.line_load = 1'b0;
        scanline_start    = 1'b0;
        check("load_on_swap_busy", line_if.line_busy, 0);
        run_load(250, 0, 1, 0, 0, 0, 0, 0, n);
        check("busy_after_abort", n, 19);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sprite_line_buffer.md
Name: sprite_line_buffer

Overview:
- Responder side of the sprite line-load handshake: accepts one sprite-slice descriptor per line_load pulse and holds line_busy while it renders.
- For each covered tile column it fetches the tile row word from tile VRAM and writes non-transparent pixels into a double-buffered scanline pixel store, resolving by z.
- The VGA side reads the display bank one pixel at a time; each read also clears the entry.

Parameters:
WIDTH, 640, visible pixels per line; x >= WIDTH is discarded.
XBITS, 10, width of x coordinates.
TILE_LATENCY, 1, cycles from tile_addr to valid tile_data (1 or 2).

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is synchronous and active-high
line_load  in  1  descriptor valid; accepted only when line_busy=0
hFlip  in  1  mirror sprite horizontally
line_z  in  2  sprite depth; higher value wins
line_palette  in  4  palette select
line_addr  in  10  sprite left screen x
tile_table  in  1  tile table select
tile_x  in  4  first tile column index in table
tile_y_total  in  4  tile row in table
tile_y_offset  in  3  pixel row within tile
sizeX  in  3  sprite width in tiles minus 1
first  in  3  first tile column to draw
last  in  3  last tile column to draw
line_busy  out  1  high from acceptance until the slice is finished
tile_addr  out  12  {tile_table, tile_y_total, tile_x+col (4b wrap), tile_y_offset}
tile_data  in  32  8 pixels x 4b; pixel i = bits [4i+3:4i]; index 0 = transparent
scanline_start  in  1  swap banks, abort draw
pixel_rd  in  1  display read strobe
pixel_x  in  10  display read x
pixel_out  out  8  {palette, index}, registered, 1-cycle latency

Behaviour:
- Reset: line_busy=0, pixel_out=0, FSM=IDLE, draw bank=0, all pixel store entries reads as 0. Clearing may take a sweep; line_busy=1 during the sweep.
- Pixel store entry: {z[1:0], palette[3:0], index[3:0]}. Two banks of WIDTH entries.
- FSM states:
  - IDLE: on line_load && !line_busy, latch all descriptor inputs. Set col=first and eff_last=min(last,sizeX). Go to FETCH next cycle with line_busy=1. If first > eff_last, go to DONE instead.
  - FETCH: drive tile_addr for col; wait TILE_LATENCY cycles, then latch the word and set pix=0.
  - READ: read draw-bank entry at target x.
  - WRITE: write if index!=0 && x<WIDTH && (stored index==0 || line_z>=stored z). Then pix+1. After pix=7: if col==eff_last go to DONE, else col+1 and go to FETCH.
  - DONE: line_busy=0 next cycle; return to IDLE.
- Timing: 2 cycles per pixel, so a single-tile slice with TILE_LATENCY=1 is busy for 1+1+16+1 cycles (acceptance to busy low).
- Target x computation:
  - cpos = hFlip ? sizeX-col : col
  - ppos = hFlip ? 7-pix : pix
  - x = line_addr + 8*cpos + ppos, truncated to 10 bits (wraps)
- Equal z: the later sprite wins.
- scanline_start: toggle the bank select. Any in-progress slice is aborted and the FSM is forced to IDLE, so line_busy=0 the next cycle. A line_load in the same cycle is ignored.
- Display read: when pixel_rd is high, pixel_out <= display[pixel_x][7:0] next cycle, and the entry is written to 0 in the same cycle. With pixel_rd low, pixel_out holds its value. If pixel_x>=WIDTH, pixel_out <= 0.
- Bank independence: draw and display banks never alias. Writes to the draw bank never affect pixel_out.

Optional Feature:
SPRITE_COLLISION_EN:
- When defined, adds output collision (1b).
- collision is sticky and set when a non-transparent sprite pixel lands on an entry whose stored index!=0, whether or not it wins.
- collision is cleared on scanline_start and on rst. Readable by the CPU via the MMIO wrapper.
- When undefined, the port is absent and there is no logic.

Test Plan:
- Basic draw: rst, then line_load with line_addr=100, sizeX=0, first=last=0, palette=3, z=1, tile_data=0x87654321. After scanline_start, read x=100..107 -> pixel_out = 0x31,0x32,...,0x38; x=99 and x=108 -> 0x00.
- hFlip and multi-tile: sizeX=1, first=0, last=1, hFlip=1, tile_x=5. tile_addr column field = 5 then 6. Tile-5 pixel 0 lands at x=line_addr+15.
- Z priority and transparency: sprite A z=2 writes 0xF at x=200; sprite B z=1 writes at x=200 -> A kept. B's index-0 pixels leave the underlying entries unchanged. A second sprite with z=2 overwrites.
- Handshake: a line_load while line_busy=1 is ignored. line_busy stays high for exactly 19 cycles on a one-tile slice.
- Boundaries: line_addr=636 -> x 636..639 written, 640..643 discarded. first=3, last=1 -> busy one cycle, nothing written.
- Abort and clear: scanline_start mid-slice -> line_busy low next cycle. Reading a pixel twice -> the second read returns 0x00. With SPRITE_COLLISION_EN, overlapping opaque sprites -> collision=1, cleared by scanline_start.
